// File: rtl/prog_updown_counter.sv
// Parametrised synchronous up/down counter with modulus, prescaled enable, parallel load,
// wrap-or-saturate boundary handling, terminal-count pulse and sticky overflow flag.
module prog_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MOD_MAX  = 255,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MOD_MAX);
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             ovf_r;
  logic [PW-1:0]    ps_r;

  logic             step_s;
  logic             boundary_s;
  logic [WIDTH-1:0] next_q_s;
  logic [WIDTH-1:0] load_clamped_s;

  // Step detection, boundary detection and the post-step count value
  always_comb begin
    step_s         = en && (ps_r == PS_LAST);
    boundary_s     = 1'b0;
    next_q_s       = q_r;
    load_clamped_s = (load_val > MAX_V) ? MAX_V : load_val;
    if (up) begin
      if (q_r >= MAX_V) begin
        boundary_s = step_s;
        next_q_s   = (SATURATE != 0) ? MAX_V : {WIDTH{1'b0}};
      end else begin
        next_q_s   = q_r + WIDTH'(1);
      end
    end else begin
      if (q_r == {WIDTH{1'b0}}) begin
        boundary_s = step_s;
        next_q_s   = (SATURATE != 0) ? {WIDTH{1'b0}} : MAX_V;
      end else begin
        next_q_s   = q_r - WIDTH'(1);
      end
    end
  end

  // Counter, prescaler and flag registers; reset > load > step > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r   <= {WIDTH{1'b0}};
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
      ps_r  <= {PW{1'b0}};
    end else if (load) begin
      q_r   <= load_clamped_s;
      tc_r  <= 1'b0;
      ps_r  <= {PW{1'b0}};
    end else begin
      if (en) begin
        ps_r <= step_s ? {PW{1'b0}} : ps_r + PW'(1);
      end else begin
        ps_r <= ps_r;
      end
      q_r  <= step_s ? next_q_s : q_r;
      tc_r <= boundary_s;
      // A boundary crossing beats a same-cycle clear
      if (boundary_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign q   = q_r;
  assign tc  = tc_r;
  assign ovf = ovf_r;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Bench for prog_updown_counter: three configurations driven by shared stimulus,
// table vectors, hand-written corner sequences and a randomized run against a reference model.
module tb_prog_updown_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] q_o   [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int n_checks = 0;
  int n_err    = 0;

  // instance 0: wrap, instance 1: saturate, instance 2: PRESCALE=3 wrap
  localparam int MODV = 9;
  int p_ps  [3] = '{1, 1, 3};
  int p_sat [3] = '{0, 1, 0};
  int mq [3], mps [3], mtc [3], movf [3];

  always #5 clk = ~clk;

  prog_updown_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1), .SATURATE(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
  prog_updown_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(1), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
  prog_updown_counter #(.WIDTH(4), .MOD_MAX(9), .PRESCALE(3), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  typedef struct {
    bit r, e, u, l; int lv; bit c;
    int eq, etc, eovf;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit u, bit l, int lv, bit c, int eq, int etc, int eovf);
    vec_t v;
    v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv; v.c = c;
    v.eq = eq; v.etc = etc; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(bit r, bit e, bit u, bit l, int lv, bit c);
    reset = r; en = e; up = u; load = l; load_val = 4'(lv); clr_ovf = c;
  endtask

  // Reference model: counting on the ring 0..MODV with plain arithmetic
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int bnd;
      bnd = 0;
      if (reset) begin
        mq[i] = 0; mps[i] = 0; mtc[i] = 0; movf[i] = 0;
      end else if (load) begin
        mq[i] = (int'(load_val) > MODV) ? MODV : int'(load_val);
        mps[i] = 0; mtc[i] = 0;
      end else begin
        if (en) begin
          mps[i] = mps[i] + 1;
          if (mps[i] == p_ps[i]) begin
            mps[i] = 0;
            bnd = up ? (mq[i] == MODV) : (mq[i] == 0);
            if (p_sat[i] != 0)
              mq[i] = up ? ((mq[i] + 1 > MODV) ? MODV : mq[i] + 1) : ((mq[i] == 0) ? 0 : mq[i] - 1);
            else
              mq[i] = up ? (mq[i] + 1) % (MODV + 1) : (mq[i] + MODV) % (MODV + 1);
          end
        end
        mtc[i] = bnd;
        if (bnd != 0) movf[i] = 1;
        else if (clr_ovf) movf[i] = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_u%0d_q", i),   int'(q_o[i]),   mq[i]);
      chk($sformatf("model_u%0d_tc", i),  int'(tc_o[i]),  mtc[i]);
      chk($sformatf("model_u%0d_ovf", i), int'(ovf_o[i]), movf[i]);
    end
  endtask

  task automatic hand(string name, int inst, int eq, int etc, int eovf);
    chk({name, "_q"},   int'(q_o[inst]),   eq);
    chk({name, "_tc"},  int'(tc_o[inst]),  etc);
    chk({name, "_ovf"}, int'(ovf_o[inst]), eovf);
  endtask

  initial begin
    vec_t vecs[$];
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mps[i] = 0; mtc[i] = 0; movf[i] = 0;
    end

    // count up through the wrap, reset, load 3 and count down through the wrap, clamp, clear
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 9; k++) vecs.push_back(mk(0, 1, 1, 0, 0, 0, k, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 15, 0, 9, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 9, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      set_in(vecs[k].r, vecs[k].e, vecs[k].u, vecs[k].l, vecs[k].lv, vecs[k].c);
      tick();
      hand($sformatf("vec%0d", k), 0, vecs[k].eq, vecs[k].etc, vecs[k].eovf);
    end

    // saturate: up at the top holds and re-pulses tc; down at zero likewise
    set_in(1, 0, 0, 0, 0, 0); tick(); hand("sat_rst", 1, 0, 0, 0);
    set_in(0, 0, 0, 1, 8, 0); tick(); hand("sat_ld8", 1, 8, 0, 0);
    set_in(0, 1, 1, 0, 0, 0); tick(); hand("sat_up1", 1, 9, 0, 0);
    tick(); hand("sat_up2", 1, 9, 1, 1);
    tick(); hand("sat_up3", 1, 9, 1, 1);
    tick(); hand("sat_up4", 1, 9, 1, 1);
    set_in(0, 0, 0, 1, 0, 1); tick(); hand("sat_ld0", 1, 0, 0, 1);
    set_in(0, 1, 0, 0, 0, 0); tick(); hand("sat_dn1", 1, 0, 1, 1);
    tick(); hand("sat_dn2", 1, 0, 1, 1);

    // prescale by 3, with an en pause of two cycles after one prescale count
    set_in(1, 0, 0, 0, 0, 0); tick(); hand("ps_rst", 2, 0, 0, 0);
    set_in(0, 1, 1, 0, 0, 0); tick(); hand("ps_c1", 2, 0, 0, 0);
    tick(); hand("ps_c2", 2, 0, 0, 0);
    tick(); hand("ps_c3", 2, 1, 0, 0);
    tick(); hand("ps_c4", 2, 1, 0, 0);
    set_in(0, 0, 1, 0, 0, 0); tick(); hand("ps_pause1", 2, 1, 0, 0);
    tick(); hand("ps_pause2", 2, 1, 0, 0);
    set_in(0, 1, 0, 0, 0, 0); tick(); hand("ps_c5", 2, 1, 0, 0);
    set_in(0, 1, 1, 0, 0, 0); tick(); hand("ps_c6", 2, 2, 0, 0);

    // load with en on the step cycle wins and clears the prescaler
    set_in(1, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 1, 0, 0, 0); tick(); tick();
    set_in(0, 1, 1, 1, 5, 0); tick(); hand("ldwin", 2, 5, 0, 0);
    set_in(0, 1, 1, 0, 0, 0); tick(); hand("ldwin_c1", 2, 5, 0, 0);
    tick(); hand("ldwin_c2", 2, 5, 0, 0);
    tick(); hand("ldwin_c3", 2, 6, 0, 0);

    // clr_ovf on the wrap cycle loses; clr_ovf alone clears
    set_in(0, 0, 0, 1, 9, 0); tick();
    set_in(0, 1, 1, 0, 0, 1); tick(); hand("clr_wrap", 0, 0, 1, 1);
    set_in(0, 0, 1, 0, 0, 1); tick(); hand("clr_alone", 0, 0, 0, 0);

    // reset together with load, mid-count with the prescaler nonzero
    set_in(0, 0, 0, 1, 6, 0); tick();
    set_in(0, 1, 1, 0, 0, 0); tick(); hand("mid_q6", 2, 6, 0, 0);
    set_in(1, 1, 1, 1, 4, 0); tick(); hand("mid_rst", 2, 0, 0, 0);
    set_in(0, 1, 1, 0, 0, 0); tick(); tick(); hand("mid_c2", 2, 0, 0, 0);
    tick(); hand("mid_c3", 2, 1, 0, 0);

    // randomized run against the model
    for (int k = 0; k < 800; k++) begin
      set_in($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 11) == 0, int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
